// File: rtl/ovc_txs_pkg.sv
// Shared definitions for the 128-bit txs burst-write stream and its loopback sink.
package ovc_txs_pkg;
   localparam int TXS_ADDR_W     = 23;
   localparam int TXS_DATA_W     = 128;
   localparam int TXS_BC_W       = 6;
   localparam int TXS_BEAT_BYTES = 16;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } burst_state_e;

   typedef struct packed {
      logic [TXS_ADDR_W-1:0] addr;
      logic [TXS_DATA_W-1:0] data;
   } txs_entry_t;
endpackage

// File: rtl/txs_burst_sink_if.sv
// Avalon-MM burst-write bus from the camera/IMU datapath master to the txs sink.
interface txs_burst_sink_if;
   import ovc_txs_pkg::*;

   logic                  txs_write;
   logic [TXS_ADDR_W-1:0] txs_address;
   logic [TXS_BC_W-1:0]   txs_burstcount;
   logic [TXS_DATA_W-1:0] txs_writedata;
   logic                  txs_waitrequest;

   modport master (
      output txs_write, txs_address, txs_burstcount, txs_writedata,
      input  txs_waitrequest
   );

   modport slave (
      input  txs_write, txs_address, txs_burstcount, txs_writedata,
      output txs_waitrequest
   );
endinterface

// File: rtl/txs_sink_fifo.sv
// Synchronous {addr, data} FIFO whose head entry sits in an output register.
module txs_sink_fifo
   import ovc_txs_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  txs_entry_t               din,
   output txs_entry_t               q,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int PW = $clog2(DEPTH);

   txs_entry_t    store [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] rd_ptr_n;
   logic [PW:0]   count_n;
   logic [PW:0]   old_left;

   always_comb begin
      rd_ptr_n = rd_ptr + PW'(pop);
      count_n  = count + (PW+1)'(push) - (PW+1)'(pop);
      old_left = count - (PW+1)'(pop);
   end

   assign full  = (count == (PW+1)'(DEPTH));
   assign empty = (count == '0);

   always_ff @(posedge clk) begin
      if (push) store[wr_ptr] <= din;
   end

   // The head register bypasses storage when the pushed beat becomes the new head.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         q      <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(push);
         rd_ptr <= rd_ptr_n;
         count  <= count_n;
         if (push && old_left == '0) q <= din;
         else                        q <= store[rd_ptr_n];
      end
   end
endmodule

// File: rtl/txs_burst_sink.sv
// Burst-write responder for the txs stream: FIFO-backed waitrequest, memory drain, stats.
// Optional random backpressure is built when TXS_SINK_PACING_EN is defined.
module txs_burst_sink
   import ovc_txs_pkg::*;
#(
   parameter int          DEPTH       = 16,
   parameter logic [15:0] PACING_SEED = 16'hACE1
) (
   input  logic                  clk125,
   input  logic                  rst,
   txs_burst_sink_if.slave       txs,
   output logic                  mem_wr,
   output logic [TXS_ADDR_W-1:0] mem_addr,
   output logic [TXS_DATA_W-1:0] mem_d,
   input  logic                  mem_ready,
   output logic                  burst_done,
   output logic [31:0]           burst_cnt,
   output logic [31:0]           beat_cnt,
   output logic                  err_zero_burst,
   output logic                  err_misalign,
   input  logic                  err_clear
);
   localparam int CW = $clog2(DEPTH) + 1;

   burst_state_e          state, state_n;
   logic [TXS_ADDR_W-1:0] addr_reg, beat_addr;
   logic [TXS_BC_W-1:0]   remaining, rem_n;
   logic                  accept, pop, done_n, set_zero, set_mis;
   logic                  pace_hold, wait_n;
   logic [CW-1:0]         fifo_count, count_n;
   logic                  fifo_full, fifo_empty;
   txs_entry_t            fifo_din, fifo_q;
   logic                  unused_ok;

   assign accept = txs.txs_write & ~txs.txs_waitrequest;
   assign pop    = mem_ready & ~fifo_empty;
   assign mem_wr = pop;
   assign mem_addr = fifo_q.addr;
   assign mem_d    = fifo_q.data;
   assign fifo_din = '{addr: beat_addr, data: txs.txs_writedata};
   assign unused_ok = ^{fifo_full, PACING_SEED};

   txs_sink_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk125),
      .rst   (rst),
      .push  (accept),
      .pop   (pop),
      .din   (fifo_din),
      .q     (fifo_q),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk125) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n   = state;
      beat_addr = addr_reg;
      rem_n     = remaining;
      done_n    = 1'b0;
      set_zero  = 1'b0;
      set_mis   = 1'b0;
      case (state)
         ST_IDLE: begin
            beat_addr = {txs.txs_address[TXS_ADDR_W-1:4], 4'h0};
            if (accept) begin
               rem_n    = txs.txs_burstcount - 6'd1;
               set_zero = (txs.txs_burstcount == '0);
               set_mis  = (txs.txs_address[3:0] != 4'h0);
               // A zero burstcount is retired as a single-beat burst.
               if (txs.txs_burstcount <= 6'd1) done_n  = 1'b1;
               else                            state_n = ST_BURST;
            end
         end
         ST_BURST: begin
            beat_addr = addr_reg + TXS_ADDR_W'(TXS_BEAT_BYTES);
            if (accept) begin
               rem_n = remaining - 6'd1;
               if (remaining == 6'd1) begin
                  done_n  = 1'b1;
                  state_n = ST_IDLE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

`ifdef TXS_SINK_PACING_EN
   logic [15:0] lfsr, lfsr_n;

   // Fibonacci taps 16,14,13,11; the post-edge value gates the next waitrequest.
   assign lfsr_n    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign pace_hold = (lfsr_n[1:0] == 2'b00);

   always_ff @(posedge clk125) begin
      if (rst) lfsr <= PACING_SEED;
      else     lfsr <= lfsr_n;
   end
`else
   assign pace_hold = 1'b0;
`endif

   assign count_n = fifo_count + CW'(accept) - CW'(pop);
   assign wait_n  = (count_n == CW'(DEPTH)) | pace_hold;

   always_ff @(posedge clk125) begin
      if (accept) begin
         addr_reg  <= beat_addr;
         remaining <= rem_n;
      end
   end

   always_ff @(posedge clk125) begin
      if (rst) begin
         txs.txs_waitrequest <= 1'b1;
         burst_done          <= 1'b0;
         burst_cnt           <= '0;
         beat_cnt            <= '0;
         err_zero_burst      <= 1'b0;
         err_misalign        <= 1'b0;
      end else begin
         txs.txs_waitrequest <= wait_n;
         burst_done          <= done_n;
         if (done_n) burst_cnt <= burst_cnt + 32'd1;
         if (accept) beat_cnt  <= beat_cnt + 32'd1;
         err_zero_burst      <= set_zero | (err_zero_burst & ~err_clear);
         err_misalign        <= set_mis  | (err_misalign   & ~err_clear);
      end
   end
endmodule

// File: tb/tb_txs_burst_sink.sv
// Scoreboard bench for txs_burst_sink: directed bursts, backpressure, wrap, errors, reset.
module tb_txs_burst_sink;
   import ovc_txs_pkg::*;

   localparam int DEPTH = 16;

   logic                  clk125 = 1'b0;
   logic                  rst = 1'b1;
   logic                  mem_ready = 1'b0;
   logic                  err_clear = 1'b0;
   logic                  mem_wr, burst_done, err_zero_burst, err_misalign;
   logic [TXS_ADDR_W-1:0] mem_addr;
   logic [TXS_DATA_W-1:0] mem_d;
   logic [31:0]           burst_cnt, beat_cnt;

   txs_burst_sink_if bus();

   txs_burst_sink #(.DEPTH(DEPTH), .PACING_SEED(16'hACE1)) dut (
      .clk125         (clk125),
      .rst            (rst),
      .txs            (bus),
      .mem_wr         (mem_wr),
      .mem_addr       (mem_addr),
      .mem_d          (mem_d),
      .mem_ready      (mem_ready),
      .burst_done     (burst_done),
      .burst_cnt      (burst_cnt),
      .beat_cnt       (beat_cnt),
      .err_zero_burst (err_zero_burst),
      .err_misalign   (err_misalign),
      .err_clear      (err_clear)
   );

   always #5 clk125 = ~clk125;

   int         checks = 0;
   int         errors = 0;
   int         done_pulses = 0;
   int         delivered = 0;
   int         cyc = 0;
   int         first_wr = -1;
   int         last_wr = -1;
   bit         duty_on = 1'b0;
   int         duty_cyc = 0;
   int         duty_wait = 0;
   txs_entry_t exp_q [$];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   always @(posedge clk125) cyc++;

   // Monitor: every presented write is popped from the scoreboard and compared.
   always @(negedge clk125) begin
      if (burst_done) done_pulses++;
      if (duty_on) begin
         duty_cyc++;
         if (bus.txs_waitrequest) duty_wait++;
      end
      if (mem_wr) begin
         if (first_wr < 0) first_wr = cyc;
         last_wr = cyc;
         if (!mem_ready) begin
            chk("mem_wr_without_ready", 1'b1, 1'b0);
         end else if (exp_q.size() == 0) begin
            chk("unexpected_mem_wr", 1'b1, 1'b0);
         end else begin
            txs_entry_t e;
            e = exp_q.pop_front();
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_d", mem_d, e.data);
            delivered++;
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk125);
      #1;
   endtask

   task automatic beat(input logic [22:0] addr, input logic [5:0] bc,
                       input logic [127:0] data, input logic [22:0] exp_addr);
      bit acc = 1'b0;
      txs_entry_t e;
      bus.txs_write      = 1'b1;
      bus.txs_address    = addr;
      bus.txs_burstcount = bc;
      bus.txs_writedata  = data;
      for (int n = 0; n < 300 && !acc; n++) begin
         @(negedge clk125);
         if (!bus.txs_waitrequest) acc = 1'b1;
         @(posedge clk125);
         #1;
      end
      if (acc) begin
         e.addr = exp_addr;
         e.data = data;
         exp_q.push_back(e);
      end else begin
         chk("beat_accept_timeout", 1'b0, 1'b1);
      end
   endtask

   task automatic idle();
      bus.txs_write      = 1'b0;
      bus.txs_address    = '0;
      bus.txs_burstcount = '0;
      bus.txs_writedata  = '0;
   endtask

   task automatic drain();
      for (int n = 0; n < 500 && exp_q.size() > 0; n++) @(negedge clk125);
      if (exp_q.size() > 0) chk("drain_timeout", exp_q.size(), 0);
      cycles(2);
   endtask

   task automatic check_reset_values(input string tag);
      @(negedge clk125);
      chk({tag, "_waitrequest"}, bus.txs_waitrequest, 1'b1);
      chk({tag, "_mem_wr"}, mem_wr, 1'b0);
      chk({tag, "_mem_addr"}, mem_addr, 23'h0);
      chk({tag, "_mem_d"}, mem_d, 128'h0);
      chk({tag, "_burst_done"}, burst_done, 1'b0);
      chk({tag, "_burst_cnt"}, burst_cnt, 32'd0);
      chk({tag, "_beat_cnt"}, beat_cnt, 32'd0);
      chk({tag, "_err_zero_burst"}, err_zero_burst, 1'b0);
      chk({tag, "_err_misalign"}, err_misalign, 1'b0);
      @(posedge clk125);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      idle();
      cycles(3);
      check_reset_values("reset");
      rst = 1'b0;
      chk("waitrequest_before_first_edge", bus.txs_waitrequest, 1'b1);
      cycles(1);
      chk("waitrequest_after_reset", bus.txs_waitrequest, 1'b0);

      // 4-beat burst at 0x100, sink always ready.
      mem_ready = 1'b1;
      first_wr = -1;
      for (int i = 0; i < 4; i++) beat(23'h000100, 6'd4, 128'(i + 1), 23'h000100 + 23'(16 * i));
      idle();
      drain();
      chk("t1_burst_cnt", burst_cnt, 32'd1);
      chk("t1_beat_cnt", beat_cnt, 32'd4);
      chk("t1_done_pulses", done_pulses, 1);
`ifndef TXS_SINK_PACING_EN
      chk("t1_back_to_back_span", last_wr - first_wr, 3);
`endif

      // 32-beat burst into a stalled sink: fills at 16, then drains in order.
      mem_ready = 1'b0;
      fork
         begin
            for (int i = 0; i < 32; i++) begin
               beat(23'h001000, 6'd32, 128'h1000 + 128'(i), 23'h001000 + 23'(16 * i));
               if (i == 15) chk("t2_waitrequest_full", bus.txs_waitrequest, 1'b1);
            end
            idle();
         end
         begin
            cycles(50);
            chk("t2_beats_held_while_full", beat_cnt, 32'd20);
            cycles(10);
            mem_ready = 1'b1;
         end
      join
      drain();
      chk("t2_burst_cnt", burst_cnt, 32'd2);
      chk("t2_beat_cnt", beat_cnt, 32'd36);
      chk("t2_done_pulses", done_pulses, 2);

      // Address wrap at the top of the 23-bit space; address input ignored mid-burst.
      beat(23'h7FFFE0, 6'd3, 128'hA0, 23'h7FFFE0);
      beat(23'h055555, 6'd9, 128'hA1, 23'h7FFFF0);
      beat(23'h055555, 6'd9, 128'hA2, 23'h000000);
      idle();
      drain();
      chk("t3_burst_cnt", burst_cnt, 32'd3);

      // Zero burstcount, then a misaligned first beat, then clearing.
      beat(23'h000200, 6'd0, 128'hB0, 23'h000200);
      idle();
      cycles(1);
      chk("t4_err_zero_burst", err_zero_burst, 1'b1);
      chk("t4_err_misalign_clean", err_misalign, 1'b0);
      beat(23'h000108, 6'd1, 128'hB1, 23'h000100);
      idle();
      cycles(1);
      chk("t4_err_misalign", err_misalign, 1'b1);
      drain();
      chk("t4_burst_cnt", burst_cnt, 32'd5);
      err_clear = 1'b1;
      cycles(1);
      err_clear = 1'b0;
      chk("t4_clear_zero_burst", err_zero_burst, 1'b0);
      chk("t4_clear_misalign", err_misalign, 1'b0);
      err_clear = 1'b1;
      beat(23'h00010C, 6'd1, 128'hB2, 23'h000100);
      err_clear = 1'b0;
      idle();
      chk("t4_set_beats_clear", err_misalign, 1'b1);
      drain();
      chk("t4_beat_cnt", beat_cnt, 32'd42);

      // Reset with a burst in flight and beats still queued.
      mem_ready = 1'b0;
      beat(23'h002000, 6'd8, 128'hC0, 23'h002000);
      beat(23'h002000, 6'd8, 128'hC1, 23'h002010);
      idle();
      rst = 1'b1;
      exp_q.delete();
      cycles(1);
      mem_ready = 1'b1;
      cycles(1);
      check_reset_values("midreset");
      rst = 1'b0;
      cycles(5);
      done_pulses = 0;
      beat(23'h000400, 6'd2, 128'hD0, 23'h000400);
      beat(23'h000400, 6'd2, 128'hD1, 23'h000410);
      idle();
      drain();
      chk("t5_burst_cnt", burst_cnt, 32'd1);
      chk("t5_beat_cnt", beat_cnt, 32'd2);
      chk("t5_done_pulses", done_pulses, 1);

`ifdef TXS_SINK_PACING_EN
      begin
         int base;
         base = delivered;
         duty_on = 1'b1;
         for (int k = 0; k < 1000; k++) beat(23'(16 * k), 6'd1, 128'h5000 + 128'(k), 23'(16 * k));
         duty_on = 1'b0;
         idle();
         drain();
         chk("t6_delivered", delivered - base, 1000);
         chk("t6_burst_cnt", burst_cnt, 32'd1001);
         chk("t6_duty_low", (duty_wait * 100 >= duty_cyc * 20), 1'b1);
         chk("t6_duty_high", (duty_wait * 100 <= duty_cyc * 30), 1'b1);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
